// File: rtl/div_32bit_seq.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed/unsigned,
// with a start/busy/done handshake toward the pipeline controller.
module div_32bit_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div0,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   dvd, dvd_nxt;      // dividend shifts out, quotient shifts in
    logic [WIDTH:0]     rem, rem_nxt;      // partial remainder
    logic [WIDTH-1:0]   ymag, ymag_nxt;
    logic               sgn, sgn_nxt;
    logic               x_neg, x_neg_nxt;
    logic               y_neg, y_neg_nxt;
    logic               div0_p, div0_p_nxt;
    logic               ovf_p, ovf_p_nxt;
    logic               busy_nxt, done_nxt, div0_nxt, ovf_nxt;
    logic [WIDTH-1:0]   q_nxt, r_nxt;

    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   trial;
    logic               no_borrow;

    // Trial subtraction as an add of the inverted divisor with carry-in 1; carry out means no borrow.
    always_comb begin
        shifted   = (WIDTH+1)'({rem, dvd[WIDTH-1]});
        trial     = {1'b0, shifted} + {1'b0, ~{1'b0, ymag}} + (WIDTH+2)'(1);
        no_borrow = trial[WIDTH+1];
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dvd_nxt    = dvd;
        rem_nxt    = rem;
        ymag_nxt   = ymag;
        sgn_nxt    = sgn;
        x_neg_nxt  = x_neg;
        y_neg_nxt  = y_neg;
        div0_p_nxt = div0_p;
        ovf_p_nxt  = ovf_p;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        q_nxt      = q;
        r_nxt      = r;
        div0_nxt   = div0;
        ovf_nxt    = ovf;

        case (state)
            S_IDLE: begin
                if (done) begin
                    busy_nxt = 1'b0;
                end else if (start) begin
                    busy_nxt   = 1'b1;
                    sgn_nxt    = sign;
                    x_neg_nxt  = sign & x[WIDTH-1];
                    y_neg_nxt  = sign & y[WIDTH-1];
                    ymag_nxt   = (sign && y[WIDTH-1]) ? (~y + WIDTH'(1)) : y;
                    cnt_nxt    = CNT_W'(WIDTH - 1);
                    ovf_p_nxt  = sign && (x == {1'b1, {(WIDTH-1){1'b0}}}) && (&y);
                    div0_p_nxt = (y == '0);
                    if (y == '0) begin
                        // Divide by zero skips the datapath: preload the fixed result.
                        dvd_nxt   = '1;
                        rem_nxt   = {1'b0, x};
                        state_nxt = S_DONE;
                    end else begin
                        dvd_nxt   = (sign && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
                        rem_nxt   = '0;
                        state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_nxt = no_borrow ? trial[WIDTH:0] : shifted;
                dvd_nxt = {dvd[WIDTH-2:0], no_borrow};
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == '0) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                if (sgn && (x_neg ^ y_neg)) begin
                    dvd_nxt = ~dvd + WIDTH'(1);
                end
                if (sgn && x_neg) begin
                    rem_nxt = {1'b0, ~rem[WIDTH-1:0] + WIDTH'(1)};
                end
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                q_nxt     = dvd;
                r_nxt     = rem[WIDTH-1:0];
                div0_nxt  = div0_p;
                ovf_nxt   = ovf_p;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            dvd    <= '0;
            rem    <= '0;
            ymag   <= '0;
            sgn    <= 1'b0;
            x_neg  <= 1'b0;
            y_neg  <= 1'b0;
            div0_p <= 1'b0;
            ovf_p  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            q      <= '0;
            r      <= '0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dvd    <= dvd_nxt;
            rem    <= rem_nxt;
            ymag   <= ymag_nxt;
            sgn    <= sgn_nxt;
            x_neg  <= x_neg_nxt;
            y_neg  <= y_neg_nxt;
            div0_p <= div0_p_nxt;
            ovf_p  <= ovf_p_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            q      <= q_nxt;
            r      <= r_nxt;
            div0   <= div0_nxt;
            ovf    <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_div_32bit_seq.sv
// Directed bench for div_32bit_seq: results, latency, handshake and async reset.
module tb_div_32bit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        busy, done, div0, ovf;
    logic [31:0] q, r;

    int cyc = 0;
    int e0 = 0;
    int checks = 0;
    int fails = 0;

    div_32bit_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .x(x), .y(y),
        .busy(busy), .done(done), .q(q), .r(r), .div0(div0), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a start for one edge, then scramble the operand inputs.
    task automatic launch(input string tag, input logic s, input logic [31:0] xx, input logic [31:0] yy);
        @(negedge clk);
        start = 1'b1; sign = s; x = xx; y = yy;
        @(posedge clk); #1;
        start = 1'b0; x = ~xx; y = 32'h5A5A_5A5A;
        e0 = cyc;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [31:0] eq, input logic [31:0] er,
                             input logic ed0, input logic eov);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(cyc - e0), 32'(lat));
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_div0"}, 32'(div0), 32'(ed0));
        check({tag, "_ovf"}, 32'(ovf), 32'(eov));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
    endtask

    task automatic after_done(input string tag, input logic [31:0] eq, input logic [31:0] er,
                              input logic ed0, input logic eov);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_q_hold"}, q, eq);
        check({tag, "_r_hold"}, r, er);
        check({tag, "_flags_hold"}, {30'd0, div0, ovf}, {30'd0, ed0, eov});
    endtask

    initial begin
        int seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_div0", 32'(div0), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned 100/7
        launch("t1", 1'b0, 32'd100, 32'd7);
        wait_done("t1", 34, 32'd14, 32'd2, 1'b0, 1'b0);
        after_done("t1", 32'd14, 32'd2, 1'b0, 1'b0);

        // Signed, remainder follows dividend
        launch("t2a", 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("t2a", 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        after_done("t2a", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        launch("t2b", 1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done("t2b", 34, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        after_done("t2b", 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);

        // Divide by zero, both modes
        launch("t3u", 1'b0, 32'h1234_5678, 32'd0);
        wait_done("t3u", 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        after_done("t3u", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        launch("t3s", 1'b1, 32'h1234_5678, 32'd0);
        wait_done("t3s", 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        after_done("t3s", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);

        // Extremes
        launch("t4a", 1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done("t4a", 34, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        after_done("t4a", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        launch("t4b", 1'b0, 32'd5, 32'hFFFF_FFFF);
        wait_done("t4b", 34, 32'd0, 32'd5, 1'b0, 1'b0);
        after_done("t4b", 32'd0, 32'd5, 1'b0, 1'b0);
        launch("t4c", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("t4c", 34, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        after_done("t4c", 32'h8000_0000, 32'd0, 1'b0, 1'b1);

        // Start while busy is ignored; start during done is deferred one cycle
        launch("t5", 1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; x = 32'd9; y = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_q_calc_hold", q, 32'h8000_0000);
        check("t5_r_calc_hold", r, 32'd0);
        wait_done("t5", 34, 32'd14, 32'd2, 1'b0, 1'b0);
        start = 1'b1; sign = 1'b0; x = 32'd9; y = 32'd3;
        @(posedge clk); #1;
        check("t5_start_in_done_ignored", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; x = 32'd0; y = 32'd0;
        e0 = cyc;
        check("t5b_busy_start", 32'(busy), 32'd1);
        wait_done("t5b", 34, 32'd3, 32'd0, 1'b0, 1'b0);
        after_done("t5b", 32'd3, 32'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-CALC
        launch("t6", 1'b0, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_q", q, 32'd0);
        check("t6_rst_r", r, 32'd0);
        check("t6_rst_flags", {30'd0, div0, ovf}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("t6_no_done_after_abort", 32'(seen), 32'd0);
        launch("t6b", 1'b0, 32'd100, 32'd7);
        wait_done("t6b", 34, 32'd14, 32'd2, 1'b0, 1'b0);
        after_done("t6b", 32'd14, 32'd2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/div_32bit_seq.md
Name: div_32bit_seq

Overview:
Multi-cycle 32-bit integer divider for the processor's execute stage. It is the subtractive counterpart to the ripple adder.
- Restoring algorithm: one quotient bit per clock.
- Each trial subtraction is built on full_adder_32bit: divisor inverted, cin=1, cout=1 means no borrow.
- Start/busy/done handshake to the pipeline controller, with signed and unsigned modes.

Parameters:
WIDTH, 32, operand/result width; all counts below are for WIDTH=32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
sign  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
x  input  32  dividend; sampled with start
y  input  32  divisor; sampled with start
busy  output  1  high from the cycle after start acceptance through the done cycle
done  output  1  one-cycle pulse, results valid
q  output  32  quotient; held until next accepted start
r  output  32  remainder; held until next accepted start
div0  output  1  divisor was zero; valid with done, held
ovf  output  1  signed overflow (x=0x80000000, y=0xFFFFFFFF, sign=1); valid with done, held

Behaviour:
- Reset (rst_n low, async): state=IDLE, busy=0, done=0, q=0, r=0, div0=0, ovf=0, counter=0. Reset mid-operation aborts the operation; no done is issued.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, register sign, x, y and the operand signs.
  - Form magnitudes: |x| and |y| if sign=1, raw values otherwise.
  - Clear the 33-bit partial remainder and set counter=31.
  - Next state: CALC if y!=0, else DONE.
- CALC, each cycle:
  - Shift the remainder left one bit; shift in the MSB of the dividend shift register.
  - Trial-subtract |y| (33-bit). If there is no borrow, keep the difference and shift 1 into the quotient; otherwise keep the shifted remainder and shift 0.
  - Counter decrements; leave for FIX after the counter-0 iteration.
  - CALC lasts exactly 32 cycles.
- FIX:
  - If sign=1 and operand signs differ, negate the quotient.
  - If sign=1 and x is negative, negate the remainder.
  - Remainder sign always follows the dividend.
  - All results wrap mod 2^32.
- DONE: drive done=1 for one cycle with q, r, div0 and ovf updated; return to IDLE.
- Latency: start sampled at edge E0.
  - Normal case: done high after edge E0+34 (1 capture + 32 CALC + 1 FIX).
  - Divide by zero: done high after edge E0+1.
- Divide by zero (y=0, either mode): q=0xFFFFFFFF, r=x (unmodified), div0=1, ovf=0; CALC and FIX are skipped.
- Signed overflow case (x=0x80000000, y=-1, sign=1): q=0x80000000, r=0, ovf=1, div0=0. Normal datapath wrap produces this; no special path.
- start while busy (CALC/FIX/DONE) is ignored; captured operands do not change.
- start asserted in the same cycle done is high is ignored; it is accepted on the next IDLE cycle.
- Operand inputs may change freely after acceptance.
- q and r hold their final values through IDLE until the DONE of the next operation. They do not update during CALC.
- div0 and ovf clear only on the next done, or on reset.

Test Plan:
1. Unsigned, sign=0, x=100, y=7, start one cycle -> busy high next cycle; done pulse exactly 34 cycles after start edge; q=14, r=2, div0=0, ovf=0.
2. Signed, sign=1, x=0xFFFFFFF9 (-7), y=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Repeat with x=7, y=0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
3. Divide by zero, x=0x12345678, y=0, both modes -> done 1 cycle after start; q=0xFFFFFFFF, r=0x12345678, div0=1.
4. Extremes:
   - unsigned x=0xFFFFFFFF, y=1 -> q=0xFFFFFFFF, r=0.
   - unsigned x=5, y=0xFFFFFFFF -> q=0, r=5.
   - signed x=0x80000000, y=0xFFFFFFFF -> q=0x80000000, r=0, ovf=1.
5. Handshake: during operation 100/7, pulse start with x=9, y=3 at cycle 10 -> ignored; result remains 14/2. A new start right after done yields q=3, r=0 after a further 34 cycles.
6. Reset: assert rst_n=0 at cycle 20 of a CALC -> all outputs 0 immediately (async), state IDLE, no done. After release, the next operation 100/7 completes correctly.
